keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 matrix keypad: drives one row low at a time, samples the four column lines, debounces the press and reports the pressed key's 2-bit row/column indices with a single-cycle `key_valid` pulse. Sits directly upstream of `keypad_decoder`: its `row`/`col` outputs feed the decoder's inputs, and `key_valid` qualifies the decoded BCD value for later stages ahead of `multiplex_display`.

## Interface
- `SCAN_CNT`, default 27000: cycles each row is driven before moving on; must be >= 4.
- `DEBOUNCE_CNT`, default 270000: consecutive stable cycles required to accept a press or a release; must be >= 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `col_in`  in  4  raw column lines, active-low with external pull-ups, asynchronous to `clk`.
- `row_out`  out  4  row drive, active-low one-hot (exactly one bit low at all times).
- `row`  out  2  row index of the last accepted key.
- `col`  out  2  column index of the last accepted key.
- `key_valid`  out  1  one-cycle pulse, asserted when a new key is accepted.
- `key_held`  out  1  high while the accepted key remains pressed, including release debounce.

## Operation
- `col_in` passes through a 2-flop synchronizer to give `col_s`. All decisions use `col_s` only.
- The row pointer `rp` runs 0..3 and wraps 3->0. `row_out` is `~(4'b0001 << rp)`.
- Press detection uses `col_s[ci]`, where `ci` is the latched column index.
- Multiple columns low: the lowest index wins. Other keys are ignored until the accepted key is released.
- State machine:
  - **SCAN**: `sc` counts 0..SCAN_CNT-1. At `sc==SCAN_CNT-1`:
    - if any `col_s` bit is 0: latch `ci` and go to DEBOUNCE with `dc=0`; `rp` is frozen;
    - otherwise advance `rp` and set `sc=0`.
  - **DEBOUNCE**:
    - if `col_s[ci]==1`: return to SCAN with `sc=0` and the same `rp`;
    - else if `dc==DEBOUNCE_CNT-1`: go to PRESSED;
    - else increment `dc`.
  - **PRESSED**: `rp` stays frozen. When `col_s[ci]==1`, go to RELEASE with `dc=0`.
  - **RELEASE**:
    - if `col_s[ci]==0`: return to PRESSED (bounce);
    - else if `dc==DEBOUNCE_CNT-1`: go to SCAN, advance `rp`, `sc=0`;
    - else increment `dc`.
- `row`/`col` load `rp`/`ci` only on the DEBOUNCE->PRESSED transition, and hold that value otherwise.
- `key_valid` is registered high for exactly the first cycle in PRESSED.
- `key_held` is 1 in PRESSED and RELEASE, and 0 elsewhere.

## Timing
- Reset values (asynchronous, immediate):
  - `row_out=4'b1110`, `row=0`, `col=0`, `key_valid=0`, `key_held=0`;
  - state SCAN, `rp=0`, `sc=0`, `dc=0`, synchronizer flops = 4'b1111.
- Column sampling happens only at the end of each row window, so the synchronizer has at least 2 cycles to settle after a row change.
- Press latency, from the SCAN sample cycle to `key_valid` high, is DEBOUNCE_CNT+1 cycles.
- `row`/`col` become valid in the same cycle `key_valid` rises, and stay stable until the next pulse.
- One physical press produces exactly one `key_valid`, regardless of bounce.
- After an accepted release, scanning resumes at the next row; a key held through the same row is not re-reported.
- Reset mid-operation: all state is abandoned and no `key_valid` is emitted.

## Structure
- Package `keypad_pkg` holds:
  - `typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kscan_state_t`;
  - default constants `KP_SCAN_CNT` and `KP_DEBOUNCE_CNT`.
- Counter widths are `$clog2` of the respective parameter.
- One sub-module, `sync_2ff` (parameterized width, reset value all-ones), instantiated for `col_in`.

## Test plan
The bench uses SCAN_CNT=4, DEBOUNCE_CNT=8 and a keypad model that drives `col_in[c]=0` while key (r,c) is closed and `row_out[r]==0`.
- Reset: hold `rst_n=0`, then release. Expect `row_out=1110`, `key_valid=0`, `key_held=0`. With no key pressed, `row_out` steps 1110->1101->1011->0111->1110 every 4 cycles.
- Clean press of key (2,1) for 40 cycles:
  - exactly one `key_valid` with `row=2`, `col=1`;
  - `key_held` stays high until 8 cycles after release;
  - next `row_out` is 0111.
- Bouncy press of key (1,3): toggle contact every 3 cycles for 24 cycles, then hold closed. Expect exactly one `key_valid` with `row=1`, `col=3`; bounce at release produces no second pulse.
- Glitch: close key (0,2) for 5 cycles only. Expect no `key_valid`, `key_held=0`, and scanning resumes on row 0.
- Simultaneous keys:
  - (3,1) and (3,3) pressed together: expect `col=1`;
  - (1,0) and (3,2) pressed together from reset: expect first report `row=1`, `col=0`; (3,2) is reported only after (1,0) is released.
- Reset mid-DEBOUNCE: assert `rst_n=0` at `dc==4`. Expect reset values in the same cycle and no `key_valid` afterwards until a new full press.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types, default timing constants and small helpers for
//             the 4x4 matrix keypad scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kscan_state_t;

  // Defaults sized for a 27 MHz clock: 1 ms per row, 10 ms debounce.
  localparam int KP_SCAN_CNT     = 27000;
  localparam int KP_DEBOUNCE_CNT = 270000;

  // Index of the lowest active-low column. Callers only use the result when
  // at least one bit is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) lowest_low = 2'(i);
    end
  endfunction

  // Active-low one-hot row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    row_drive = ~(4'b0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for asynchronous level inputs. Resets to
//             all-ones so idle pulled-up lines read as inactive.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Scans a 4x4 active-low matrix keypad one row at a time,
//             debounces press and release, and reports the accepted key's
//             row/column with a single-cycle key_valid pulse.
//             SCAN_CNT must be >= 4 so the column synchronizer settles
//             inside each row window; DEBOUNCE_CNT must be >= 2.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CNT     = KP_SCAN_CNT,
  parameter int DEBOUNCE_CNT = KP_DEBOUNCE_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SC_W = $clog2(SCAN_CNT);
  localparam int DC_W = $clog2(DEBOUNCE_CNT);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CNT - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CNT - 1);

  logic [3:0]      col_s;
  kscan_state_t    state;
  logic [1:0]      rp;
  logic [1:0]      ci;
  logic [SC_W-1:0] sc;
  logic [DC_W-1:0] dc;

  sync_2ff #(
    .WIDTH (4)
  ) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_in),
    .q     (col_s)
  );

  // Scan/debounce state machine. Columns are only sampled at the end of a
  // row window, so the synchronizer always reflects the current row. Once a
  // column is latched the row is frozen until the key is fully released,
  // which keeps every other key masked for the duration of the press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      rp        <= 2'd0;
      ci        <= 2'd0;
      sc        <= '0;
      dc        <= '0;
      row_out   <= 4'b1110;
      row       <= 2'd0;
      col       <= 2'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (sc == SC_LAST) begin
            if (col_s != 4'hF) begin
              ci    <= lowest_low(col_s);
              dc    <= '0;
              state <= DEBOUNCE;
            end else begin
              rp      <= rp + 2'd1;
              row_out <= row_drive(rp + 2'd1);
              sc      <= '0;
            end
          end else begin
            sc <= sc + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (col_s[ci]) begin
            // Contact opened before it was stable: retry the same row.
            sc    <= '0;
            state <= SCAN;
          end else if (dc == DC_LAST) begin
            row       <= rp;
            col       <= ci;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= PRESSED;
          end else begin
            dc <= dc + 1'b1;
          end
        end

        PRESSED: begin
          if (col_s[ci]) begin
            dc    <= '0;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          if (!col_s[ci]) begin
            // Release bounce: still the same press, no new report.
            state <= PRESSED;
          end else if (dc == DC_LAST) begin
            rp       <= rp + 2'd1;
            row_out  <= row_drive(rp + 2'd1);
            sc       <= '0;
            key_held <= 1'b0;
            state    <= SCAN;
          end else begin
            dc <= dc + 1'b1;
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
